// File: rtl/adder_pkg.sv
// Shared constants and helpers for the pipelined adder family.
// Keeps the default geometry and the stage-count rule in one place.
`timescale 1ns/1ps
package adder_pkg;

   localparam int DEFAULT_WIDTH = 16;
   localparam int DEFAULT_CHUNK = 4;

   // Returns 0 for an illegal geometry so the top level can refuse to elaborate.
   function automatic int calc_stages(input int width, input int chunk);
      if (chunk < 1 || width < chunk || (width % chunk) != 0) begin
         return 0;
      end
      return width / chunk;
   endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit ripple adder built from fulladder cells.
// Each bit's carry lives in its own generate scope so the chain stays a clean DAG.
`timescale 1ns/1ps
module adder_chunk #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             ci,
   output logic [CHUNK-1:0] s,
   output logic             co
);

   for (genvar i = 0; i < CHUNK; i++) begin : g_bit
      logic ci_bit;
      logic co_bit;

      if (i == 0) begin : g_first
         assign ci_bit = ci;
      end else begin : g_next
         assign ci_bit = g_bit[i-1].co_bit;
      end

      fulladder u_fa (
         .a  (a[i]),
         .b  (b[i]),
         .ci (ci_bit),
         .s  (s[i]),
         .co (co_bit)
      );
   end

   assign co = g_bit[CHUNK-1].co_bit;

endmodule

// File: rtl/fulladder.sv
// Single-bit full adder cell used as the ripple element of every adder slice.
`timescale 1ns/1ps
module fulladder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder/subtractor: one CHUNK-bit slice resolved per stage,
// carry handed stage to stage, valid/ready handshake on both ends.
`timescale 1ns/1ps
module pipelined_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CHUNK = DEFAULT_CHUNK
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             ovf
);

   localparam int STAGES = calc_stages(WIDTH, CHUNK);
   localparam int NS     = (STAGES < 1) ? 1 : STAGES;
   localparam int LAST   = NS - 1;

   if (STAGES < 1) begin : g_bad_cfg
      $error("pipelined_adder: WIDTH must be a positive integer multiple of CHUNK");
   end

   logic adv;

   logic             st_v   [NS];
   logic [WIDTH-1:0] st_a   [NS];
   logic [WIDTH-1:0] st_b   [NS];
   logic [WIDTH-1:0] st_sum [NS];
   logic             st_ci  [NS];

   logic [CHUNK-1:0] chunk_s  [NS];
   logic             chunk_co [NS];

   logic             valid_d [NS];
   logic             valid_q [NS];
   logic             carry_d [NS];
   logic             carry_q [NS];
   logic [WIDTH-1:0] sum_d   [NS];
   logic [WIDTH-1:0] sum_q   [NS];
   logic [WIDTH-1:0] a_d     [NS];
   logic [WIDTH-1:0] a_q     [NS];
   logic [WIDTH-1:0] b_d     [NS];
   logic [WIDTH-1:0] b_q     [NS];
   logic             ovf_d;
   logic             ovf_q;

   assign adv      = !valid_q[LAST] || out_ready;
   assign in_ready = adv;

   // Stage 0 sees the ports with b pre-inverted for subtraction; later stages see the previous register.
   always_comb begin
      st_v[0]   = in_valid;
      st_a[0]   = a;
      st_b[0]   = b ^ {WIDTH{sub}};
      st_ci[0]  = sub ? 1'b1 : cin;
      st_sum[0] = '0;
      for (int k = 1; k < NS; k++) begin
         st_v[k]   = valid_q[k-1];
         st_a[k]   = a_q[k-1];
         st_b[k]   = b_q[k-1];
         st_ci[k]  = carry_q[k-1];
         st_sum[k] = sum_q[k-1];
      end
   end

   for (genvar k = 0; k < NS; k++) begin : g_stage
      adder_chunk #(
         .CHUNK (CHUNK)
      ) u_chunk (
         .a  (st_a[k][k*CHUNK +: CHUNK]),
         .b  (st_b[k][k*CHUNK +: CHUNK]),
         .ci (st_ci[k]),
         .s  (chunk_s[k]),
         .co (chunk_co[k])
      );
   end

   // The whole pipe moves together; lower result slices ride along unchanged as skew registers.
   always_comb begin
      for (int k = 0; k < NS; k++) begin
         valid_d[k] = valid_q[k];
         carry_d[k] = carry_q[k];
         sum_d[k]   = sum_q[k];
         a_d[k]     = a_q[k];
         b_d[k]     = b_q[k];
         if (adv) begin
            valid_d[k]                  = st_v[k];
            carry_d[k]                  = chunk_co[k];
            sum_d[k]                    = st_sum[k];
            sum_d[k][k*CHUNK +: CHUNK]  = chunk_s[k];
            a_d[k]                      = st_a[k];
            b_d[k]                      = st_b[k];
         end
      end
      ovf_d = ovf_q;
      if (adv) begin
         ovf_d = (st_a[LAST][WIDTH-1] == st_b[LAST][WIDTH-1]) &&
                 (chunk_s[LAST][CHUNK-1] != st_a[LAST][WIDTH-1]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NS; k++) begin
            valid_q[k] <= 1'b0;
            carry_q[k] <= 1'b0;
            sum_q[k]   <= '0;
            a_q[k]     <= '0;
            b_q[k]     <= '0;
         end
         ovf_q <= 1'b0;
      end else begin
         for (int k = 0; k < NS; k++) begin
            valid_q[k] <= valid_d[k];
            carry_q[k] <= carry_d[k];
            sum_q[k]   <= sum_d[k];
            a_q[k]     <= a_d[k];
            b_q[k]     <= b_d[k];
         end
         ovf_q <= ovf_d;
      end
   end

   assign out_valid = valid_q[LAST];
   assign sum       = sum_q[LAST];
   assign carry     = carry_q[LAST];
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: directed vector table, stall and reset
// sequences on a 16/4 instance, plus random sweeps on 8/8, 32/4 and 12/3 instances.
`timescale 1ns/1ps
module tb_pipelined_adder;

   localparam int NOPS = 1000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        cin;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] sum;
   logic        carry;
   logic        ovf;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pipelined_adder #(
      .WIDTH (16),
      .CHUNK (4)
   ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .carry     (carry),
      .ovf       (ovf)
   );

   // Arithmetic reference: plain integer add/subtract plus a signed range check for overflow.
   function automatic void refModel(input int w, input longint unsigned ua, input longint unsigned ub,
                                    input bit c, input bit s, output longint unsigned rsum,
                                    output bit rc, output bit ro);
      longint unsigned modv;
      longint unsigned tot;
      longint          sa;
      longint          sb;
      longint          sres;
      modv = 64'd1 << w;
      sa   = (ua >= modv / 2) ? longint'(ua) - longint'(modv) : longint'(ua);
      sb   = (ub >= modv / 2) ? longint'(ub) - longint'(modv) : longint'(ub);
      if (s) begin
         rsum = (ua - ub) & (modv - 1);
         rc   = (ua >= ub);
         sres = sa - sb;
      end else begin
         tot  = ua + ub + 64'(c);
         rsum = tot & (modv - 1);
         rc   = (tot >= modv);
         sres = sa + sb + longint'(c);
      end
      ro = (sres >= longint'(modv / 2)) || (sres < -longint'(modv / 2));
   endfunction

   function automatic logic [63:0] packRes(input int w, input longint unsigned s, input bit c, input bit o);
      longint unsigned m;
      m = (64'd1 << w) - 1;
      return (64'(o) << (w + 1)) | (64'(c) << w) | (s & m);
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Drives one operation, then waits (bounded) for its result with out_ready held high.
   task automatic applyStimulus(input logic [15:0] va, input logic [15:0] vb, input logic vcin,
                                input logic vsub, output logic [15:0] rs, output logic rc,
                                output logic ro, output int lat);
      @(negedge clk);
      a         = va;
      b         = vb;
      cin       = vcin;
      sub       = vsub;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat      = 1;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      rs = sum;
      rc = carry;
      ro = ovf;
   endtask

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic        sub;
      logic [15:0] sum;
      logic        carry;
      logic        ovf;
   } vec_t;

   vec_t vecs [10];

   // Parameter sweep instances, each with its own reset and random driver.
   for (genvar g = 0; g < 3; g++) begin : g_sweep
      localparam int W = (g == 0) ? 8 : (g == 1) ? 32 : 12;
      localparam int C = (g == 0) ? 8 : (g == 1) ? 4 : 3;
      localparam int S = W / C;

      logic         sw_rst_n;
      logic         sw_in_valid;
      logic         sw_in_ready;
      logic [W-1:0] sw_a;
      logic [W-1:0] sw_b;
      logic         sw_cin;
      logic         sw_sub;
      logic         sw_out_valid;
      logic         sw_out_ready;
      logic [W-1:0] sw_sum;
      logic         sw_carry;
      logic         sw_ovf;
      bit           done_flag = 1'b0;

      pipelined_adder #(
         .WIDTH (W),
         .CHUNK (C)
      ) u_dut (
         .clk       (clk),
         .rst_n     (sw_rst_n),
         .in_valid  (sw_in_valid),
         .in_ready  (sw_in_ready),
         .a         (sw_a),
         .b         (sw_b),
         .cin       (sw_cin),
         .sub       (sw_sub),
         .out_valid (sw_out_valid),
         .out_ready (sw_out_ready),
         .sum       (sw_sum),
         .carry     (sw_carry),
         .ovf       (sw_ovf)
      );

      initial begin : sweep_proc
         logic [63:0]     exp_q [$];
         int              cyc_q [$];
         int              sent;
         int              got;
         int              cyc;
         int              pc;
         longint unsigned rs;
         bit              rc;
         bit              ro;
         sw_rst_n     = 1'b0;
         sw_in_valid  = 1'b0;
         sw_out_ready = 1'b1;
         sw_a         = '0;
         sw_b         = '0;
         sw_cin       = 1'b0;
         sw_sub       = 1'b0;
         repeat (3) @(negedge clk);
         sw_rst_n = 1'b1;
         sent = 0;
         got  = 0;
         cyc  = 0;
         while (got < NOPS && cyc < 4 * NOPS + 200) begin
            @(negedge clk);
            cyc++;
            if (sw_out_valid) begin
               if (exp_q.size() == 0) begin
                  checkOutput($sformatf("sweep %0d/%0d unexpected result", W, C), 64'd1, 64'd0);
               end else begin
                  pc = cyc_q.pop_front();
                  checkOutput($sformatf("sweep %0d/%0d result %0d", W, C, got),
                              packRes(W, 64'(sw_sum), sw_carry, sw_ovf), exp_q.pop_front());
                  checkOutput($sformatf("sweep %0d/%0d latency %0d", W, C, got),
                              64'(cyc - pc), 64'(S));
               end
               got++;
            end
            if (sent < NOPS && $urandom_range(0, 3) != 0) begin
               sw_a   = W'($urandom);
               sw_b   = W'($urandom);
               sw_cin = 1'($urandom);
               sw_sub = 1'($urandom);
               if ($urandom_range(0, 9) == 0) sw_a = '1;
               if ($urandom_range(0, 9) == 0) sw_b = '0;
               sw_in_valid = 1'b1;
               refModel(W, 64'(sw_a), 64'(sw_b), sw_cin, sw_sub, rs, rc, ro);
               exp_q.push_back(packRes(W, rs, rc, ro));
               cyc_q.push_back(cyc);
               sent++;
            end else begin
               sw_in_valid = 1'b0;
            end
         end
         checkOutput($sformatf("sweep %0d/%0d completed ops", W, C), 64'(got), 64'(NOPS));
         done_flag = 1'b1;
      end
   end

   initial begin : main_proc
      logic [15:0]     rs;
      logic            rc;
      logic            ro;
      int              lat;
      logic [15:0]     opa [8];
      logic [15:0]     opb [8];
      logic            opc [8];
      logic            ops [8];
      logic [63:0]     exp_q [$];
      logic [17:0]     held;
      bit              stall_seen;
      int              nsent;
      int              ngot;
      int              stale;
      longint unsigned msum;
      bit              mc;
      bit              mo;

      vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
      vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
      vecs[5] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
      vecs[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
      vecs[7] = '{16'h0007, 16'h0007, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
      vecs[8] = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0};
      vecs[9] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;
      cin       = 1'b0;
      sub       = 1'b0;

      // Reset state with the clock running.
      repeat (3) @(negedge clk);
      checkOutput("reset out_valid", 64'(out_valid), 64'd0);
      checkOutput("reset sum", 64'(sum), 64'd0);
      checkOutput("reset carry", 64'(carry), 64'd0);
      checkOutput("reset ovf", 64'(ovf), 64'd0);
      rst_n = 1'b1;
      #1;
      checkOutput("in_ready after release", 64'(in_ready), 64'd1);

      // Directed vectors.
      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, rs, rc, ro, lat);
         checkOutput($sformatf("vec%0d latency", i), 64'(lat), 64'd4);
         checkOutput($sformatf("vec%0d sum", i), 64'(rs), 64'(vecs[i].sum));
         checkOutput($sformatf("vec%0d carry", i), 64'(rc), 64'(vecs[i].carry));
         checkOutput($sformatf("vec%0d ovf", i), 64'(ro), 64'(vecs[i].ovf));
      end
      repeat (2) @(negedge clk);

      // Back-to-back stream with a three-cycle output stall.
      for (int i = 0; i < 8; i++) begin
         opa[i] = 16'($urandom);
         opb[i] = 16'($urandom);
         opc[i] = 1'($urandom);
         ops[i] = 1'($urandom);
      end
      nsent      = 0;
      ngot       = 0;
      stall_seen = 1'b0;
      held       = '0;
      for (int t = 0; t < 60 && ngot < 8; t++) begin
         @(negedge clk);
         out_ready = !(t >= 6 && t <= 8);
         #1;
         if (out_valid && !out_ready) begin
            checkOutput($sformatf("stall in_ready t%0d", t), 64'(in_ready), 64'd0);
            if (stall_seen) checkOutput($sformatf("stall hold t%0d", t), 64'({ovf, carry, sum}), 64'(held));
            held       = {ovf, carry, sum};
            stall_seen = 1'b1;
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checkOutput("stream unexpected result", 64'd1, 64'd0);
            end else begin
               checkOutput($sformatf("stream result %0d", ngot), packRes(16, 64'(sum), carry, ovf),
                           exp_q.pop_front());
            end
            ngot++;
         end
         if (nsent < 8) begin
            a        = opa[nsent];
            b        = opb[nsent];
            cin      = opc[nsent];
            sub      = ops[nsent];
            in_valid = 1'b1;
            if (in_ready) begin
               refModel(16, 64'(opa[nsent]), 64'(opb[nsent]), opc[nsent], ops[nsent], msum, mc, mo);
               exp_q.push_back(packRes(16, msum, mc, mo));
               nsent++;
            end
         end else begin
            in_valid = 1'b0;
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      checkOutput("stream results received", 64'(ngot), 64'd8);
      checkOutput("stall observed", 64'(stall_seen), 64'd1);
      repeat (2) @(negedge clk);

      // Reset asserted with one result presented and three more in flight.
      for (int t = 0; t < 4; t++) begin
         @(negedge clk);
         a        = 16'h0100 + 16'(t);
         b        = 16'h0001;
         cin      = 1'b0;
         sub      = 1'b0;
         in_valid = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checkOutput("pre-reset out_valid", 64'(out_valid), 64'd1);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("mid-stream reset out_valid", 64'(out_valid), 64'd0);
      checkOutput("mid-stream reset sum", 64'(sum), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      stale = 0;
      repeat (8) begin
         @(negedge clk);
         #1;
         if (out_valid) stale++;
      end
      checkOutput("no stale result after reset", 64'(stale), 64'd0);
      applyStimulus(16'h1111, 16'h2222, 1'b1, 1'b0, rs, rc, ro, lat);
      checkOutput("post-reset latency", 64'(lat), 64'd4);
      checkOutput("post-reset sum", 64'(rs), 64'h3334);
      checkOutput("post-reset carry", 64'(rc), 64'd0);

      // Let the parameter sweeps finish.
      for (int t = 0; t < 10000 && !(g_sweep[0].done_flag && g_sweep[1].done_flag && g_sweep[2].done_flag); t++) begin
         @(negedge clk);
      end
      checkOutput("sweeps finished", 64'(g_sweep[0].done_flag && g_sweep[1].done_flag && g_sweep[2].done_flag),
                  64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
